execute_stage: RTL and testbench

Execute stage of the five-stage pipelined ARM-subset core. It consumes the Decode/Execute pipeline register outputs and performs four jobs: operand forwarding, the ALU operation, condition evaluation against the architectural NZCV flags register, and predication of the control signals. It drives the Execute/Memory register, the branch-redirect path and the hazard unit. It owns the NZCV register.

---
 rtl/pipeline_pkg.sv | 33 +++
 rtl/cond_unit.sv | 62 ++++++
 rtl/execute_stage.sv | 155 +++++++++++++++
 tb/tb_execute_stage.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipelined ARM-subset core.
package pipeline_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [3:0] {
    COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
    COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_ALT
  } cond_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_BUSY = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_t;

endpackage

// File: rtl/cond_unit.sv
// NZCV flags register, condition-code decode and predicated flag-write gating.
module cond_unit
  import pipeline_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] i_cond,
  input  logic [1:0] i_flag_write,
  input  logic [3:0] i_nzcv,
  input  logic       i_hold,
  output logic       o_cond_ex,
  output logic [3:0] o_flags
);

  logic [3:0] r_flags;
  logic       w_n, w_z, w_c, w_v;

  assign w_n = r_flags[FLAG_N];
  assign w_z = r_flags[FLAG_Z];
  assign w_c = r_flags[FLAG_C];
  assign w_v = r_flags[FLAG_V];

  always_comb begin
    o_cond_ex = 1'b1;
    case (i_cond)
      COND_EQ: o_cond_ex = w_z;
      COND_NE: o_cond_ex = ~w_z;
      COND_CS: o_cond_ex = w_c;
      COND_CC: o_cond_ex = ~w_c;
      COND_MI: o_cond_ex = w_n;
      COND_PL: o_cond_ex = ~w_n;
      COND_VS: o_cond_ex = w_v;
      COND_VC: o_cond_ex = ~w_v;
      COND_HI: o_cond_ex = w_c & ~w_z;
      COND_LS: o_cond_ex = ~w_c | w_z;
      COND_GE: o_cond_ex = (w_n == w_v);
      COND_LT: o_cond_ex = (w_n != w_v);
      COND_GT: o_cond_ex = ~w_z & (w_n == w_v);
      COND_LE: o_cond_ex = w_z | (w_n != w_v);
      default: o_cond_ex = 1'b1;
    endcase
  end

  // Flags written by this instruction are only seen by the next one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flags <= '0;
    end else if (o_cond_ex && !i_hold) begin
      if (i_flag_write[1]) begin
        r_flags[FLAG_N] <= i_nzcv[FLAG_N];
        r_flags[FLAG_Z] <= i_nzcv[FLAG_Z];
      end
      if (i_flag_write[0]) begin
        r_flags[FLAG_C] <= i_nzcv[FLAG_C];
        r_flags[FLAG_V] <= i_nzcv[FLAG_V];
      end
    end
  end

  assign o_flags = r_flags;

endmodule

// File: rtl/execute_stage.sv
// Execute stage: forwarding, ALU, condition evaluation and predication.
// Optional iterative multiplier built when MUL_EN is defined.
module execute_stage
  import pipeline_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] rd1_e,
  input  logic [WIDTH-1:0] rd2_e,
  input  logic [WIDTH-1:0] ext_imm_e,
  input  logic [WIDTH-1:0] result_w,
  input  logic [WIDTH-1:0] alu_out_m,
  input  logic [1:0]       forward_a_e,
  input  logic [1:0]       forward_b_e,
  input  logic             alu_src_e,
  input  logic [1:0]       alu_control_e,
  input  logic [1:0]       flag_write_e,
  input  logic [3:0]       cond_e,
  input  logic             pcsrc_e,
  input  logic             reg_write_e,
  input  logic             mem_write_e,
  input  logic             branch_e,
  input  logic             mul_e,
  output logic [WIDTH-1:0] alu_result_e,
  output logic [WIDTH-1:0] write_data_e,
  output logic             pcsrc_o,
  output logic             reg_write_o,
  output logic             mem_write_o,
  output logic             branch_taken_o,
  output logic [3:0]       flags_o,
  output logic             stall_o
);

  logic [WIDTH-1:0] w_src_a, w_fwd_b, w_src_b, w_bb, w_alu, w_res;
  logic [WIDTH:0]   w_sum;
  logic             w_sub, w_arith, w_cond_ex, w_mul_done, w_mul_pending;
  logic [1:0]       w_fw;
  logic [3:0]       w_nzcv;

  always_comb begin
    case (forward_a_e)
      FWD_WB:  w_src_a = result_w;
      FWD_MEM: w_src_a = alu_out_m;
      default: w_src_a = rd1_e;
    endcase
    case (forward_b_e)
      FWD_WB:  w_fwd_b = result_w;
      FWD_MEM: w_fwd_b = alu_out_m;
      default: w_fwd_b = rd2_e;
    endcase
  end

  assign w_src_b      = alu_src_e ? ext_imm_e : w_fwd_b;
  assign write_data_e = w_fwd_b;

  // SUB runs through the adder as a + ~b + 1 so C is the no-borrow flag.
  assign w_sub   = (alu_control_e == ALU_SUB);
  assign w_arith = ~alu_control_e[1];
  assign w_bb    = w_sub ? ~w_src_b : w_src_b;
  assign w_sum   = {1'b0, w_src_a} + {1'b0, w_bb} + (WIDTH+1)'(w_sub);

  always_comb begin
    case (alu_control_e)
      ALU_ADD, ALU_SUB: w_alu = w_sum[WIDTH-1:0];
      ALU_AND:          w_alu = w_src_a & w_src_b;
      default:          w_alu = w_src_a | w_src_b;
    endcase
  end

  assign w_nzcv[FLAG_N] = w_res[WIDTH-1];
  assign w_nzcv[FLAG_Z] = (w_res == '0);
  assign w_nzcv[FLAG_C] = w_sum[WIDTH];
  assign w_nzcv[FLAG_V] = (w_src_a[WIDTH-1] == w_bb[WIDTH-1]) &
                          (w_sum[WIDTH-1] != w_src_a[WIDTH-1]);

  // Logic ops and multiply results never touch C/V.
  assign w_fw = {flag_write_e[1], flag_write_e[0] & w_arith & ~w_mul_done};

  cond_unit u_cond (
    .clk          (clk),
    .reset        (reset),
    .i_cond       (cond_e),
    .i_flag_write (w_fw),
    .i_nzcv       (w_nzcv),
    .i_hold       (stall_o),
    .o_cond_ex    (w_cond_ex),
    .o_flags      (flags_o)
  );

`ifdef MUL_EN
  localparam int CW = $clog2(WIDTH);

  mul_state_t       r_state, w_next;
  logic [WIDTH-1:0] r_mcand, r_mplier, r_prod;
  logic [CW-1:0]    r_cnt;
  logic             w_issue;

  assign w_issue = (r_state == MUL_IDLE) & mul_e & w_cond_ex;

  always_comb begin
    w_next = r_state;
    case (r_state)
      MUL_IDLE: if (w_issue) w_next = MUL_BUSY;
      MUL_BUSY: if (r_cnt == CW'(WIDTH-1)) w_next = MUL_DONE;
      default:  w_next = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= MUL_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_next;
      if (w_issue) begin
        r_mcand  <= w_src_a;
        r_mplier <= w_src_b;
        r_prod   <= '0;
        r_cnt    <= '0;
      end else if (r_state == MUL_BUSY) begin
        if (r_mplier[0]) r_prod <= r_prod + r_mcand;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CW'(1);
      end
    end
  end

  assign w_mul_done    = (r_state == MUL_DONE);
  assign w_mul_pending = (r_state == MUL_BUSY) | w_issue;
  // Gated by reset so the stall drops the instant reset asserts.
  assign stall_o       = reset & w_mul_pending;
  assign w_res         = w_mul_done ? r_prod : w_alu;
`else
  logic w_unused_mul;

  assign w_unused_mul  = mul_e;
  assign w_mul_done    = 1'b0;
  assign w_mul_pending = 1'b0;
  assign stall_o       = 1'b0;
  assign w_res         = w_alu;
`endif

  assign alu_result_e   = w_res;
  assign pcsrc_o        = pcsrc_e & w_cond_ex;
  assign reg_write_o    = reg_write_e & w_cond_ex & ~w_mul_pending;
  assign mem_write_o    = mem_write_e & w_cond_ex;
  assign branch_taken_o = branch_e & w_cond_ex;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed scenarios plus randomized
// ALU/flag/predication traffic checked against an arithmetic reference model.
module tb_execute_stage;

  logic        clk, reset;
  logic [31:0] rd1_e, rd2_e, ext_imm_e, result_w, alu_out_m;
  logic [1:0]  forward_a_e, forward_b_e, alu_control_e, flag_write_e;
  logic        alu_src_e;
  logic [3:0]  cond_e;
  logic        pcsrc_e, reg_write_e, mem_write_e, branch_e, mul_e;
  logic [31:0] alu_result_e, write_data_e;
  logic        pcsrc_o, reg_write_o, mem_write_o, branch_taken_o, stall_o;
  logic [3:0]  flags_o;

  int total = 0;
  int bad   = 0;
  logic [3:0] m_flags;

  execute_stage #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .ext_imm_e(ext_imm_e),
    .result_w(result_w), .alu_out_m(alu_out_m),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .alu_src_e(alu_src_e), .alu_control_e(alu_control_e),
    .flag_write_e(flag_write_e), .cond_e(cond_e),
    .pcsrc_e(pcsrc_e), .reg_write_e(reg_write_e), .mem_write_e(mem_write_e),
    .branch_e(branch_e), .mul_e(mul_e),
    .alu_result_e(alu_result_e), .write_data_e(write_data_e),
    .pcsrc_o(pcsrc_o), .reg_write_o(reg_write_o), .mem_write_o(mem_write_o),
    .branch_taken_o(branch_taken_o), .flags_o(flags_o), .stall_o(stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ARM condition semantics on an NZCV nibble.
  function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cf && !z;
      4'd9:  return !cf || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  // Reference ALU using wide unsigned/signed arithmetic.
  function automatic void alu_model(input logic [31:0] a, input logic [31:0] b,
                                    input logic [1:0] op, output logic [31:0] r,
                                    output logic n, output logic z,
                                    output logic c, output logic v,
                                    output logic arith);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 1'b0; v = 1'b0; arith = 1'b0;
    case (op)
      2'd0: begin
        r = a + b; arith = 1'b1;
        c = (longint'(a) + longint'(b)) > 64'sh0FFFFFFFF;
        s = sa + sb;
        v = (s > 64'sh7FFFFFFF) || (s < -64'sh80000000);
      end
      2'd1: begin
        r = a - b; arith = 1'b1;
        c = (a >= b);
        s = sa - sb;
        v = (s > 64'sh7FFFFFFF) || (s < -64'sh80000000);
      end
      2'd2: r = a & b;
      default: r = a | b;
    endcase
    n = r[31];
    z = (r == 32'd0);
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'h7FFFFFFF;
      3: return 32'h80000000;
      4: return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                       input logic [1:0] fw, input logic [3:0] c);
    rd1_e = a; rd2_e = b; ext_imm_e = 32'd0;
    result_w = 32'hDEAD0001; alu_out_m = 32'hDEAD0002;
    forward_a_e = 2'b00; forward_b_e = 2'b00; alu_src_e = 1'b0;
    alu_control_e = op; flag_write_e = fw; cond_e = c;
    pcsrc_e = 1'b0; reg_write_e = 1'b1; mem_write_e = 1'b0; branch_e = 1'b0; mul_e = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    mul_e = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    m_flags = 4'b0000;
  endtask

  task automatic test_reset();
    drive(0, 0, 2'd0, 2'b00, 4'he);
    reset = 1'b0;
    #1;
    total++;
    if (flags_o !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", flags_o); end
    total++;
    if (stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
    @(negedge clk);
    reset = 1'b1;
    m_flags = 4'b0000;
  endtask

  task automatic test_forwarding();
    @(negedge clk);
    drive(5, 3, 2'd0, 2'b00, 4'he);
    alu_out_m = 9; forward_a_e = 2'b10;
    #1;
    total++;
    if (alu_result_e !== 32'd12) begin bad++; $display("FAIL fwd_mem_a got=%0d exp=12", alu_result_e); end
    forward_b_e = 2'b01; result_w = 100;
    #1;
    total++;
    if (alu_result_e !== 32'd109 || write_data_e !== 32'd100) begin
      bad++; $display("FAIL fwd_wb_b got=%0d/%0d exp=109/100", alu_result_e, write_data_e);
    end
    forward_b_e = 2'b11; forward_a_e = 2'b11;
    #1;
    total++;
    if (alu_result_e !== 32'd8 || write_data_e !== 32'd3) begin
      bad++; $display("FAIL fwd_reg11 got=%0d/%0d exp=8/3", alu_result_e, write_data_e);
    end
  endtask

  task automatic test_sub_flags();
    @(negedge clk);
    drive(3, 3, 2'd1, 2'b11, 4'he);
    #1;
    total++;
    if (alu_result_e !== 32'd0) begin bad++; $display("FAIL sub_result got=%0d exp=0", alu_result_e); end
    @(posedge clk); #1;
    total++;
    if (flags_o !== 4'b0110) begin bad++; $display("FAIL sub_flags got=%b exp=0110", flags_o); end
    m_flags = 4'b0110;
  endtask

  task automatic test_predication();
    @(negedge clk);
    drive(1, 2, 2'd0, 2'b11, 4'h1);
    mem_write_e = 1'b1; branch_e = 1'b1; pcsrc_e = 1'b1;
    #1;
    total++;
    if ({reg_write_o, mem_write_o, branch_taken_o, pcsrc_o} !== 4'b0000) begin
      bad++; $display("FAIL pred_ne got=%b exp=0000", {reg_write_o, mem_write_o, branch_taken_o, pcsrc_o});
    end
    @(posedge clk); #1;
    total++;
    if (flags_o !== 4'b0110) begin bad++; $display("FAIL pred_flags got=%b exp=0110", flags_o); end
    @(negedge clk);
    cond_e = 4'h0;
    #1;
    total++;
    if ({reg_write_o, mem_write_o, branch_taken_o, pcsrc_o} !== 4'b1111) begin
      bad++; $display("FAIL pred_eq got=%b exp=1111", {reg_write_o, mem_write_o, branch_taken_o, pcsrc_o});
    end
    flag_write_e = 2'b00;
  endtask

  task automatic test_overflow();
    @(negedge clk);
    drive(32'h7FFFFFFF, 32'h55, 2'd0, 2'b11, 4'he);
    alu_src_e = 1'b1; ext_imm_e = 32'd1;
    #1;
    total++;
    if (alu_result_e !== 32'h80000000 || write_data_e !== 32'h55) begin
      bad++; $display("FAIL ovf_result got=%h/%h exp=80000000/55", alu_result_e, write_data_e);
    end
    @(posedge clk); #1;
    total++;
    if (flags_o !== 4'b1001) begin bad++; $display("FAIL ovf_flags got=%b exp=1001", flags_o); end
    m_flags = 4'b1001;
  endtask

  task automatic test_random();
    logic [31:0] ea, eb, er;
    logic n, z, c, v, ar, ce;
    do_reset();
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      drive(pick(), pick(), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)));
      ext_imm_e = pick(); result_w = $urandom; alu_out_m = $urandom;
      forward_a_e = 2'($urandom_range(0, 3)); forward_b_e = 2'($urandom_range(0, 3));
      alu_src_e = 1'($urandom_range(0, 1));
      pcsrc_e = 1'($urandom_range(0, 1)); reg_write_e = 1'($urandom_range(0, 1));
      mem_write_e = 1'($urandom_range(0, 1)); branch_e = 1'($urandom_range(0, 1));
      ea = (forward_a_e == 2'b01) ? result_w : (forward_a_e == 2'b10) ? alu_out_m : rd1_e;
      eb = (forward_b_e == 2'b01) ? result_w : (forward_b_e == 2'b10) ? alu_out_m : rd2_e;
      alu_model(ea, alu_src_e ? ext_imm_e : eb, alu_control_e, er, n, z, c, v, ar);
      ce = cond_model(cond_e, m_flags);
      #1;
      total++;
      if (alu_result_e !== er) begin bad++; $display("FAIL rnd_result i=%0d got=%h exp=%h", i, alu_result_e, er); end
      total++;
      if (write_data_e !== eb) begin bad++; $display("FAIL rnd_wdata i=%0d got=%h exp=%h", i, write_data_e, eb); end
      total++;
      if ({pcsrc_o, reg_write_o, mem_write_o, branch_taken_o} !==
          ({pcsrc_e, reg_write_e, mem_write_e, branch_e} & {4{ce}})) begin
        bad++; $display("FAIL rnd_ctrl i=%0d got=%b cond=%h flags=%b", i,
                        {pcsrc_o, reg_write_o, mem_write_o, branch_taken_o}, cond_e, m_flags);
      end
      if (ce) begin
        if (flag_write_e[1]) begin m_flags[3] = n; m_flags[2] = z; end
        if (flag_write_e[0] && ar) begin m_flags[1] = c; m_flags[0] = v; end
      end
      @(posedge clk); #1;
      total++;
      if (flags_o !== m_flags) begin bad++; $display("FAIL rnd_flags i=%0d got=%b exp=%b", i, flags_o, m_flags); end
    end
  endtask

`ifdef MUL_EN
  // Issues a multiply that was set up by the caller, counts stall cycles and
  // checks the DONE cycle; returns with the FSM in DONE.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [3:0] hold_flags,
                         input string tag);
    int cnt, rw_bad, fl_bad;
    cnt = 0; rw_bad = 0; fl_bad = 0;
    #1;
    while (stall_o === 1'b1 && cnt < 100) begin
      cnt++;
      if (reg_write_o !== 1'b0) rw_bad++;
      if (flags_o !== hold_flags) fl_bad++;
      @(negedge clk); #1;
    end
    total++;
    if (cnt != 33) begin bad++; $display("FAIL %s_stall_len got=%0d exp=33", tag, cnt); end
    total++;
    if (rw_bad != 0) begin bad++; $display("FAIL %s_rw_busy got=%0d bad cycles exp=0", tag, rw_bad); end
    total++;
    if (fl_bad != 0) begin bad++; $display("FAIL %s_flags_hold got=%0d bad cycles exp=0", tag, fl_bad); end
    total++;
    if (alu_result_e !== a * b) begin bad++; $display("FAIL %s_product got=%h exp=%h", tag, alu_result_e, a * b); end
    total++;
    if (reg_write_o !== 1'b1) begin bad++; $display("FAIL %s_rw_done got=%b exp=1", tag, reg_write_o); end
  endtask

  task automatic test_mul();
    logic [31:0] ra, rb;
    do_reset();
    @(negedge clk);
    drive(3, 3, 2'd1, 2'b11, 4'he);
    @(negedge clk);
    drive(6, 7, 2'd0, 2'b10, 4'he);
    mul_e = 1'b1;
    run_mul(6, 7, 4'b0110, "mul67");
    @(posedge clk); #1;
    total++;
    if (flags_o !== 4'b0010) begin bad++; $display("FAIL mul_flags got=%b exp=0010", flags_o); end
    @(negedge clk);
    mul_e = 1'b0;
    #1;
    total++;
    if (stall_o !== 1'b0 || alu_result_e !== 32'd13) begin
      bad++; $display("FAIL mul_after got=%b/%0d exp=0/13", stall_o, alu_result_e);
    end
    for (int k = 0; k < 2; k++) begin
      ra = $urandom; rb = $urandom;
      @(negedge clk);
      drive(ra, rb, 2'd0, 2'b00, 4'hf);
      mul_e = 1'b1;
      run_mul(ra, rb, 4'b0010, "mulrnd");
      @(negedge clk);
      mul_e = 1'b0;
    end
  endtask

  task automatic test_mul_reset();
    do_reset();
    @(negedge clk);
    drive(6, 7, 2'd0, 2'b00, 4'h0);
    mul_e = 1'b1;
    #1;
    total++;
    if (stall_o !== 1'b0 || reg_write_o !== 1'b0) begin
      bad++; $display("FAIL mul_condfail got=%b/%b exp=0/0", stall_o, reg_write_o);
    end
    @(negedge clk);
    drive(3, 3, 2'd1, 2'b11, 4'he);
    @(negedge clk);
    drive(6, 7, 2'd0, 2'b00, 4'he);
    mul_e = 1'b1;
    for (int k = 0; k < 11; k++) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (stall_o !== 1'b0 || flags_o !== 4'b0000) begin
      bad++; $display("FAIL mul_reset got=%b/%b exp=0/0000", stall_o, flags_o);
    end
    @(negedge clk);
    reset = 1'b1;
    run_mul(6, 7, 4'b0000, "mul_postrst");
    @(negedge clk);
    mul_e = 1'b0;
  endtask
`else
  task automatic test_no_mul();
    @(negedge clk);
    drive(6, 7, 2'd0, 2'b00, 4'he);
    mul_e = 1'b1;
    #1;
    total++;
    if (stall_o !== 1'b0 || reg_write_o !== 1'b1 || alu_result_e !== 32'd13) begin
      bad++; $display("FAIL nomul got=%b/%b/%0d exp=0/1/13", stall_o, reg_write_o, alu_result_e);
    end
    @(posedge clk); #1;
    total++;
    if (stall_o !== 1'b0) begin bad++; $display("FAIL nomul_stall got=%b exp=0", stall_o); end
    @(negedge clk);
    mul_e = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b0;
    m_flags = 4'b0000;
    test_reset();
    test_forwarding();
    test_sub_flags();
    test_predication();
    test_overflow();
`ifdef MUL_EN
    test_mul();
    test_mul_reset();
`else
    test_no_mul();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
